// File: rtl/timer_pkg.sv
// ============================================================================
// Module      : timer_pkg
// Description : Shared defaults and mode encoding for the multi-channel timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

    localparam int C_PRESCALE_DIV = 50000;
    localparam int C_PRE_W        = 16;
    localparam int C_N_CH         = 4;
    localparam int C_CNT_W        = 16;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } timer_mode_e;

endpackage

`default_nettype wire

// File: rtl/timer_channel.sv
// ============================================================================
// Module      : timer_channel
// Description : One tick-counting channel, one-shot or periodic, stop > start > tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = C_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [CNT_W-1:0] period,
    output logic             timeout,
    output logic             busy
);

    logic [CNT_W-1:0] r_per_lat;
    logic [CNT_W-1:0] r_rem;
    logic             r_busy;
    logic             r_timeout;
    timer_mode_e      w_mode;
    logic             w_start_ok;

    assign w_mode     = timer_mode_e'(periodic);
    assign w_start_ok = start && (period != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_per_lat <= '0;
            r_rem     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (stop) begin
                r_busy <= 1'b0;
            end else if (w_start_ok) begin
                r_per_lat <= period;
                r_rem     <= period;
                r_busy    <= 1'b1;
            end else if (tick && r_busy) begin
                if (r_rem == CNT_W'(1)) begin
                    r_timeout <= 1'b1;
                    // Mode is looked at only now, so it may change while counting.
                    if (w_mode == MODE_PERIODIC) begin
                        r_rem <= r_per_lat;
                    end else begin
                        r_rem  <= '0;
                        r_busy <= 1'b0;
                    end
                end else begin
                    r_rem <= r_rem - CNT_W'(1);
                end
            end
        end
    end

    assign timeout = r_timeout;
    assign busy    = r_busy;

endmodule

`default_nettype wire

// File: rtl/multi_channel_timer.sv
// ============================================================================
// Module      : multi_channel_timer
// Description : Shared base-tick prescaler driving N_CH independent interval timers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_channel_timer
    import timer_pkg::*;
#(
    parameter int PRESCALE_DIV = C_PRESCALE_DIV,
    parameter int PRE_W        = C_PRE_W,
    parameter int N_CH         = C_N_CH,
    parameter int CNT_W        = C_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH-1:0]       stop,
    input  logic [N_CH-1:0]       periodic,
    input  logic [N_CH*CNT_W-1:0] period,
    output logic                  tick,
    output logic [N_CH-1:0]       timeout,
    output logic [N_CH-1:0]       busy
);

    logic [PRE_W-1:0] r_pre_cnt;
    logic             r_tick;

    // A frozen prescaler keeps its partial count so resuming finishes the interval.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pre_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (enable) begin
            if (r_pre_cnt == PRE_W'(PRESCALE_DIV - 1)) begin
                r_pre_cnt <= '0;
                r_tick    <= 1'b1;
            end else begin
                r_pre_cnt <= r_pre_cnt + PRE_W'(1);
                r_tick    <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            timer_channel #(
                .CNT_W (CNT_W)
            ) u_channel (
                .clk      (clk),
                .rst      (rst),
                .tick     (r_tick),
                .start    (start[i]),
                .stop     (stop[i]),
                .periodic (periodic[i]),
                .period   (period[i*CNT_W +: CNT_W]),
                .timeout  (timeout[i]),
                .busy     (busy[i])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_timer.sv
// ============================================================================
// Module      : tb_multi_channel_timer
// Description : Directed scoreboard bench; expected timeout cycles are queued per channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multi_channel_timer;

    localparam int PRESCALE_DIV = 4;
    localparam int PRE_W        = 3;
    localparam int N_CH         = 2;
    localparam int CNT_W        = 8;

    logic                  clk      = 1'b0;
    logic                  rst      = 1'b0;
    logic                  enable   = 1'b1;
    logic [N_CH-1:0]       start    = '0;
    logic [N_CH-1:0]       stop     = '0;
    logic [N_CH-1:0]       periodic = '0;
    logic [N_CH*CNT_W-1:0] period   = '0;
    logic                  tick;
    logic [N_CH-1:0]       timeout;
    logic [N_CH-1:0]       busy;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;
    int exp_q0[$];
    int exp_q1[$];
    int mon_e;

    multi_channel_timer #(
        .PRESCALE_DIV (PRESCALE_DIV),
        .PRE_W        (PRE_W),
        .N_CH         (N_CH),
        .CNT_W        (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .period   (period),
        .tick     (tick),
        .timeout  (timeout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    // Inputs written here are present for cycle n and sampled at the edge ending it.
    task automatic go_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input int n);
        go_to(n);
        @(negedge clk);
    endtask

    // Timeout monitor: every pulse must match the oldest queued expected cycle.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int i = 0; i < N_CH; i++) begin
                if (timeout[i] === 1'b1) begin
                    n_cmp++;
                    mon_e = -1;
                    if (i == 0 && exp_q0.size() > 0) mon_e = exp_q0.pop_front();
                    if (i == 1 && exp_q1.size() > 0) mon_e = exp_q1.pop_front();
                    if (mon_e != cyc) begin
                        n_err++;
                        $display("FAIL timeout[%0d]: pulse at cycle %0d, expected cycle %0d (-1 = none)",
                                 i, cyc, mon_e);
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset and free-running prescaler; first tick in cycle 6, then every 4
        sample(1);
        check("rst_tick", 32'(tick), 32'(0));
        check("rst_timeout", 32'(timeout), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        go_to(2);
        rst = 1'b1;
        for (int c = 2; c <= 25; c++) begin
            sample(c);
            check("s1_tick", 32'(tick), 32'((c >= 6) && ((c - 6) % 4 == 0)));
            check("s1_timeout", 32'(timeout), 32'(0));
            check("s1_busy", 32'(busy), 32'(0));
        end

        // 2: ch0 one-shot, period 3; ticks 30,34,38 -> timeout in 39
        period[0*CNT_W +: CNT_W] = 8'd3;
        periodic[0] = 1'b0;
        go_to(27); start[0] = 1'b1; exp_q0.push_back(39);
        go_to(28); start[0] = 1'b0;
        sample(28); check("s2_busy_on", 32'(busy[0]), 32'(1));
        sample(38); check("s2_busy_hold", 32'(busy[0]), 32'(1));
        sample(39); check("s2_busy_off", 32'(busy[0]), 32'(0));
        sample(50); check("s2_busy_stay", 32'(busy[0]), 32'(0));

        // 3: ch1 periodic, period 2 -> pulses 59,67,75,83; stop before 91
        period[1*CNT_W +: CNT_W] = 8'd2;
        periodic[1] = 1'b1;
        go_to(51); start[1] = 1'b1;
        exp_q1.push_back(59); exp_q1.push_back(67); exp_q1.push_back(75); exp_q1.push_back(83);
        go_to(52); start[1] = 1'b0;
        sample(52); check("s3_busy_on", 32'(busy[1]), 32'(1));
        sample(84); check("s3_busy_hold", 32'(busy[1]), 32'(1));
        go_to(85); stop[1] = 1'b1;
        go_to(86); stop[1] = 1'b0;
        sample(86); check("s3_stop_busy", 32'(busy[1]), 32'(0));
        sample(96); check("s3_stop_stay", 32'(busy[1]), 32'(0));

        // 4a: start on tick cycle 98 -> that tick ignored, expiry 119
        period[0*CNT_W +: CNT_W] = 8'd5;
        go_to(98); start[0] = 1'b1; exp_q0.push_back(119);
        go_to(99); start[0] = 1'b0;
        sample(99);  check("s4_busy_on", 32'(busy[0]), 32'(1));
        sample(118); check("s4_busy_hold", 32'(busy[0]), 32'(1));
        sample(120); check("s4_busy_off", 32'(busy[0]), 32'(0));
        // 4b: restart at rem=1 (cycle 140) -> five fresh ticks, expiry 159 not 143
        go_to(122); start[0] = 1'b1; exp_q0.push_back(159);
        go_to(123); start[0] = 1'b0;
        go_to(140); start[0] = 1'b1;
        go_to(141); start[0] = 1'b0;
        sample(143); check("s4_restart_busy", 32'(busy[0]), 32'(1));
        sample(160); check("s4_restart_done", 32'(busy[0]), 32'(0));
        // 4c: stop and start together while busy -> stopped, no expiry
        go_to(162); start[0] = 1'b1;
        go_to(163); start[0] = 1'b0;
        sample(163); check("s4_pre_stop", 32'(busy[0]), 32'(1));
        go_to(164); start[0] = 1'b1; stop[0] = 1'b1;
        go_to(165); start[0] = 1'b0; stop[0] = 1'b0;
        sample(165); check("s4_stopstart", 32'(busy[0]), 32'(0));
        sample(190); check("s4_stopstart_stay", 32'(busy[0]), 32'(0));

        // 5a: enable low 10 cycles mid-count -> expiry 203 moves to 213
        period[0*CNT_W +: CNT_W] = 8'd3;
        go_to(192); start[0] = 1'b1; exp_q0.push_back(213);
        go_to(193); start[0] = 1'b0;
        go_to(195); enable = 1'b0;
        sample(198); check("s5_gated_tick", 32'(tick), 32'(0));
        go_to(205); enable = 1'b1;
        sample(208); check("s5_resumed_tick", 32'(tick), 32'(1));
        sample(212); check("s5_busy_hold", 32'(busy[0]), 32'(1));
        // 5b: period 0 start is ignored
        period[1*CNT_W +: CNT_W] = 8'd0;
        go_to(218); start[1] = 1'b1;
        go_to(219); start[1] = 1'b0;
        sample(219); check("s5_zero_period", 32'(busy[1]), 32'(0));
        // 5c: period 255 one-shot; ticks every 4 from 224 -> 255th at 1240
        period[1*CNT_W +: CNT_W] = 8'd255;
        periodic[1] = 1'b0;
        go_to(221); start[1] = 1'b1; exp_q1.push_back(1241);
        go_to(222); start[1] = 1'b0;
        sample(222);  check("s5_max_busy", 32'(busy[1]), 32'(1));
        sample(1240); check("s5_max_hold", 32'(busy[1]), 32'(1));
        sample(1241); check("s5_max_done", 32'(busy[1]), 32'(0));

        // 6: reset while both busy -> everything cleared, prescaler restarts
        period[0*CNT_W +: CNT_W] = 8'd5;
        period[1*CNT_W +: CNT_W] = 8'd2;
        periodic = 2'b10;
        go_to(1250); start = 2'b11;
        go_to(1251); start = 2'b00;
        sample(1251); check("s6_both_busy", 32'(busy), 32'(3));
        go_to(1254); rst = 1'b0;
        go_to(1255); rst = 1'b1;
        sample(1255);
        check("s6_rst_tick", 32'(tick), 32'(0));
        check("s6_rst_timeout", 32'(timeout), 32'(0));
        check("s6_rst_busy", 32'(busy), 32'(0));
        sample(1258); check("s6_pre_tick", 32'(tick), 32'(0));
        sample(1259); check("s6_first_tick", 32'(tick), 32'(1));
        sample(1263); check("s6_second_tick", 32'(tick), 32'(1));
        sample(1280); check("s6_busy_stay", 32'(busy), 32'(0));
        go_to(1300);

        check("q0_drained", 32'(exp_q0.size()), 32'(0));
        check("q1_drained", 32'(exp_q1.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
